lobster_cache_ctrl: RTL

Request front-end and miss handler placed directly upstream of lobster_cache. Accepts read/write/invalidate requests from the core over a valid/ready handshake. Keeps a tag+valid shadow store so hits can be told apart from aliasing. Serves hits from the cache, refills misses from memory, writes through to memory, and drives the cache's we/inv/addr_in/data_in/addr_out pins.

---
 rtl/lobster_cache_pkg.sv | 34 +++
 rtl/lobster_cache_tags.sv | 49 ++++
 rtl/lobster_cache_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/lobster_cache_pkg.sv
// Shared definitions for lobster_cache and its controller: index hash,
// request opcodes and controller state encoding.
package lobster_cache_pkg;

    localparam logic [63:0] C1 = 64'hbf58476d1ce4e5b9;
    localparam logic [63:0] C2 = 64'h94d049bb133111eb;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_INV   = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        MISS_WAIT,
        WR_REQ,
        FILL,
        INV,
        RESP
    } state_t;

    // 64-bit mixer; the cache index is its low bits.
    function automatic logic [63:0] cache_hash(input logic [63:0] x);
        logic [63:0] z;
        z = x;
        z = (z ^ (z >> 30)) * C1;
        z = (z ^ (z >> 27)) * C2;
        z = z ^ (z >> 31);
        return z;
    endfunction

endpackage

// File: rtl/lobster_cache_tags.sv
// Tag shadow store: per-index tag plus valid bit. Combinational read port,
// one write/invalidate port; valid vector clears asynchronously on reset.
module lobster_cache_tags #(
    parameter int ADDR_WIDTH  = 36,
    parameter int NUM_ENTRIES = 8192,
    parameter int INDEX_BITS  = $clog2(NUM_ENTRIES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH-1:0] rd_tag,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic                  wr_en,
    input  logic                  inv_en,
    input  logic [ADDR_WIDTH-1:0] wr_tag
);

    logic [NUM_ENTRIES-1:0] valid_q, valid_d;
    logic [ADDR_WIDTH-1:0]  tag_q [NUM_ENTRIES];

    always_comb begin
        valid_d = valid_q;
        if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
        end else if (inv_en) begin
            valid_d[wr_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag contents need no reset: a stale tag is masked by its valid bit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx] <= wr_tag;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];

endmodule

// File: rtl/lobster_cache_ctrl.sv
// Request front-end and miss handler for lobster_cache: one request at a time,
// hit detection via tag shadow, read refill and write-through to memory.
module lobster_cache_ctrl
    import lobster_cache_pkg::*;
#(
    parameter int ADDR_WIDTH  = 36,
    parameter int DATA_WIDTH  = 64,
    parameter int NUM_ENTRIES = 8192
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_hit,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_we,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rsp_data,
    output logic                  cache_we,
    output logic                  cache_inv,
    output logic [ADDR_WIDTH-1:0] cache_addr_in,
    output logic [DATA_WIDTH-1:0] cache_data_in,
    output logic [ADDR_WIDTH-1:0] cache_addr_out,
    input  logic [DATA_WIDTH-1:0] cache_data_out
);

    localparam int INDEX_BITS = $clog2(NUM_ENTRIES);

    state_t                state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  hit_q, hit_d;

    logic [INDEX_BITS-1:0] idx;
    logic                  tag_valid;
    logic [ADDR_WIDTH-1:0] tag_rd;
    logic                  lookup_hit;
    logic                  tag_wr;
    logic                  tag_inv;

    assign idx        = INDEX_BITS'(cache_hash(64'(addr_q)));
    assign lookup_hit = tag_valid && (tag_rd == addr_q);

    lobster_cache_tags #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_ENTRIES(NUM_ENTRIES),
        .INDEX_BITS (INDEX_BITS)
    ) u_tags (
        .clk     (clk),
        .rst     (rst),
        .rd_idx  (idx),
        .rd_valid(tag_valid),
        .rd_tag  (tag_rd),
        .wr_idx  (idx),
        .wr_en   (tag_wr),
        .inv_en  (tag_inv),
        .wr_tag  (addr_q)
    );

    // Both cache address pins follow the latched request so the cache's
    // valid gating and its read port always refer to the same entry.
    assign cache_addr_in  = addr_q;
    assign cache_addr_out = addr_q;
    assign cache_data_in  = data_q;
    assign mem_req_addr   = addr_q;
    assign mem_req_wdata  = data_q;

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        addr_d        = addr_q;
        data_d        = data_q;
        hit_d         = hit_q;
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;
        rsp_hit       = 1'b0;
        rsp_data      = '0;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        cache_we      = 1'b0;
        cache_inv     = 1'b0;
        tag_wr        = 1'b0;
        tag_inv       = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    op_d   = req_op;
                    addr_d = req_addr;
                    data_d = req_wdata;
                    hit_d  = 1'b0;
                    case (req_op)
                        OP_READ:         state_d = LOOKUP;
                        OP_WRITE:        state_d = WR_REQ;
                        OP_INV, OP_RSVD: state_d = INV;
                        default:         state_d = INV;
                    endcase
                end
            end
            LOOKUP: begin
                if (lookup_hit) begin
                    data_d  = cache_data_out;
                    hit_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    state_d = MISS_REQ;
                end
            end
            MISS_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_d = MISS_WAIT;
            end
            MISS_WAIT: begin
                if (mem_rsp_valid) begin
                    data_d  = mem_rsp_data;
                    state_d = FILL;
                end
            end
            WR_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                if (mem_req_ready) state_d = FILL;
            end
            FILL: begin
                cache_we = 1'b1;
                tag_wr   = 1'b1;
                state_d  = RESP;
            end
            INV: begin
                cache_inv = 1'b1;
                tag_inv   = 1'b1;
                state_d   = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_hit   = hit_q;
                rsp_data  = (op_q == OP_READ) ? data_q : '0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            hit_q   <= hit_d;
        end
    end

endmodule
